// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the LSU-side SRAM controller.
// Holds the FSM state encoding, SRAM geometry and the per-phase pin helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 16;
    localparam int ADDR_MSB = 18;
    localparam int ADDR_LSB = 2;
    localparam int WORD_AW  = ADDR_MSB - ADDR_LSB + 1;

    // Strobe and data-bus settings for one half-word phase.
    typedef struct packed {
        logic               we_n;
        logic               oe_n;
        logic               lb_n;
        logic               ub_n;
        logic               dq_oe;
        logic [SRAM_DW-1:0] dq_out;
    } pins_t;

    localparam pins_t PINS_IDLE = '{
        we_n:   1'b1,
        oe_n:   1'b1,
        lb_n:   1'b1,
        ub_n:   1'b1,
        dq_oe:  1'b0,
        dq_out: '0
    };

    // Pin values for the first cycle of a phase. Stores open with we_n low
    // because every phase has at least one write cycle before the hold cycle.
    function automatic pins_t phase_pins(input logic        hi,
                                         input logic        wren,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  bmask);
        pins_t p;
        p = PINS_IDLE;
        if (wren) begin
            p.we_n   = 1'b0;
            p.dq_oe  = 1'b1;
            p.dq_out = hi ? wdata[31:16] : wdata[15:0];
            p.lb_n   = hi ? ~bmask[2] : ~bmask[0];
            p.ub_n   = hi ? ~bmask[3] : ~bmask[1];
        end else begin
            p.oe_n = 1'b0;
            p.lb_n = 1'b0;
            p.ub_n = 1'b0;
        end
        return p;
    endfunction

    // A load always runs both halves; a store half runs only if it has a byte enabled.
    function automatic logic half_used(input logic       hi,
                                       input logic       wren,
                                       input logic [3:0] bmask);
        return !wren || (hi ? (|bmask[3:2]) : (|bmask[1:0]));
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// 32-bit load/store responder driving a 256K x 16 asynchronous SRAM.
// Each word access runs as a low half-word phase then a high half-word phase,
// each WAIT_CYCLES+1 clocks long; store halves with no enabled bytes are skipped.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_req_vld,
    output logic               o_req_rdy,
    input  logic               i_req_wren,
    input  logic [31:0]        i_req_addr,
    input  logic [31:0]        i_req_wdata,
    input  logic [3:0]         i_req_bmask,
    output logic               o_resp_vld,
    output logic [31:0]        o_rdata,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [SRAM_DW-1:0] io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n
);

    localparam int            CW       = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               wren_q;
    logic [WORD_AW-1:0] word_q;
    logic [31:0]        wdata_q;
    logic [3:0]         bmask_q;
    pins_t              pins;
    logic               last_cycle;
    logic               unused_addr_bits;

    assign last_cycle       = (cnt == CNT_LAST);
    assign unused_addr_bits = ^{i_req_addr[31:ADDR_MSB+1], i_req_addr[ADDR_LSB-1:0]};

    assign io_sram_dq  = pins.dq_oe ? pins.dq_out : {SRAM_DW{1'bz}};
    assign o_sram_we_n = pins.we_n;
    assign o_sram_oe_n = pins.oe_n;
    assign o_sram_lb_n = pins.lb_n;
    assign o_sram_ub_n = pins.ub_n;

    // Sequencer: accepts a request, walks the half-word phases and registers every pin.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            wren_q      <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            pins        <= PINS_IDLE;
            o_req_rdy   <= 1'b1;
            o_resp_vld  <= 1'b0;
            o_rdata     <= '0;
            o_sram_addr <= '0;
            o_sram_ce_n <= 1'b1;
        end else begin
            o_resp_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_vld) begin
                        wren_q    <= i_req_wren;
                        word_q    <= i_req_addr[ADDR_MSB:ADDR_LSB];
                        wdata_q   <= i_req_wdata;
                        bmask_q   <= i_req_bmask;
                        o_req_rdy <= 1'b0;
                        cnt       <= '0;
                        if (half_used(1'b0, i_req_wren, i_req_bmask)) begin
                            state       <= LO;
                            o_sram_ce_n <= 1'b0;
                            o_sram_addr <= {i_req_addr[ADDR_MSB:ADDR_LSB], 1'b0};
                            pins        <= phase_pins(1'b0, i_req_wren, i_req_wdata, i_req_bmask);
                        end else if (half_used(1'b1, i_req_wren, i_req_bmask)) begin
                            state       <= HI;
                            o_sram_ce_n <= 1'b0;
                            o_sram_addr <= {i_req_addr[ADDR_MSB:ADDR_LSB], 1'b1};
                            pins        <= phase_pins(1'b1, i_req_wren, i_req_wdata, i_req_bmask);
                        end else begin
                            state      <= RESP;
                            o_resp_vld <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (last_cycle) begin
                        if (!wren_q) begin
                            o_rdata[15:0] <= io_sram_dq;
                        end
                        cnt <= '0;
                        if (half_used(1'b1, wren_q, bmask_q)) begin
                            state       <= HI;
                            o_sram_addr <= {word_q, 1'b1};
                            pins        <= phase_pins(1'b1, wren_q, wdata_q, bmask_q);
                        end else begin
                            state       <= RESP;
                            o_resp_vld  <= 1'b1;
                            o_sram_ce_n <= 1'b1;
                            pins        <= PINS_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (wren_q && (cnt + CNT_ONE == CNT_LAST)) begin
                            pins.we_n <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (last_cycle) begin
                        if (!wren_q) begin
                            o_rdata[31:16] <= io_sram_dq;
                        end
                        cnt         <= '0;
                        state       <= RESP;
                        o_resp_vld  <= 1'b1;
                        o_sram_ce_n <= 1'b1;
                        pins        <= PINS_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (wren_q && (cnt + CNT_ONE == CNT_LAST)) begin
                            pins.we_n <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    o_req_rdy <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    o_req_rdy   <= 1'b1;
                    o_sram_ce_n <= 1'b1;
                    pins        <= PINS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a word-level reference memory predicts load data and
// completion timing, and a pin-level SRAM model sits on the bus.
module tb_sram_ctrl;

    localparam int WAIT = 1;
    localparam int CYC  = WAIT + 1;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic        i_req_wren;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_bmask;
    logic        o_resp_vld;
    logic [31:0] o_rdata;
    logic [17:0] o_sram_addr;
    wire  [15:0] io_sram_dq;
    logic        o_sram_ce_n;
    logic        o_sram_we_n;
    logic        o_sram_oe_n;
    logic        o_sram_lb_n;
    logic        o_sram_ub_n;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sram_mem [0:262143];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata;
    logic [31:0] hold_addr;
    int          bad;

    sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req_vld   (i_req_vld),
        .o_req_rdy   (o_req_rdy),
        .i_req_wren  (i_req_wren),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_bmask (i_req_bmask),
        .o_resp_vld  (o_resp_vld),
        .o_rdata     (o_rdata),
        .o_sram_addr (o_sram_addr),
        .io_sram_dq  (io_sram_dq),
        .o_sram_ce_n (o_sram_ce_n),
        .o_sram_we_n (o_sram_we_n),
        .o_sram_oe_n (o_sram_oe_n),
        .o_sram_lb_n (o_sram_lb_n),
        .o_sram_ub_n (o_sram_ub_n)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 i_clk = ~i_clk;

    // A released bus floats high so a stray driver shows up as a non-FFFF value.
    pullup (io_sram_dq);

    // SRAM read path: drives the bus whenever it is selected for reading.
    assign io_sram_dq = (!o_sram_ce_n && !o_sram_oe_n && o_sram_we_n) ? sram_mem[o_sram_addr] : 16'hzzzz;

    // SRAM write path: captures enabled bytes mid-cycle while we_n is low.
    always @(negedge i_clk) begin
        if (!o_sram_ce_n && !o_sram_we_n) begin
            if (!o_sram_lb_n) sram_mem[o_sram_addr][7:0]  <= io_sram_dq[7:0];
            if (!o_sram_ub_n) sram_mem[o_sram_addr][15:8] <= io_sram_dq[15:8];
        end
    end

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
    end

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
    endfunction

    task automatic ref_write(input logic [16:0] w, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] word;
        word = ref_read(w);
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
        end
        ref_mem[int'(w)] = word;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, follows it cycle by cycle to its response and checks
    // pins, latency and data against the reference memory.
    task automatic apply_stimulus(input string tag, input logic wren, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] bmask, input bit keep_vld);
        logic [16:0] w;
        logic        halves [2];
        logic        hb;
        int          nph, exp_resp, resp_c, active, pbad, ph, pos, wait_c, bi;
        w           = addr[18:2];
        i_req_vld   = 1'b1;
        i_req_wren  = wren;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_bmask = bmask;
        wait_c = 0;
        while (!o_req_rdy && wait_c < 20) begin
            tick();
            wait_c++;
        end
        check_output({tag, " rdy before accept"}, 32'(o_req_rdy), 32'd1);
        tick();
        if (keep_vld) begin
            i_req_wren  = 1'b0;
            i_req_addr  = $urandom;
            i_req_wdata = $urandom;
            i_req_bmask = 4'($urandom);
            hold_addr   = i_req_addr;
        end else begin
            i_req_vld   = 1'b0;
            i_req_wren  = 1'($urandom);
            i_req_addr  = $urandom;
            i_req_wdata = $urandom;
            i_req_bmask = 4'($urandom);
        end
        nph = 0;
        halves[0] = 1'b0;
        halves[1] = 1'b1;
        if (wren) begin
            if (|bmask[1:0]) begin halves[nph] = 1'b0; nph++; end
            if (|bmask[3:2]) begin halves[nph] = 1'b1; nph++; end
        end else begin
            nph = 2;
        end
        exp_resp = nph * CYC + 1;
        resp_c = 0;
        active = 0;
        pbad   = 0;
        for (int c = 1; c <= 4 * CYC + 4; c++) begin
            if (!o_sram_ce_n) begin
                ph  = active / CYC;
                pos = active % CYC;
                active++;
                if (ph >= nph) begin
                    pbad++;
                end else begin
                    hb = halves[ph];
                    bi = hb ? 2 : 0;
                    if (o_sram_addr !== {w, hb}) pbad++;
                    if (wren) begin
                        if (o_sram_oe_n !== 1'b1) pbad++;
                        if (o_sram_we_n !== ((pos < WAIT) ? 1'b0 : 1'b1)) pbad++;
                        if (io_sram_dq !== (hb ? wdata[31:16] : wdata[15:0])) pbad++;
                        if (o_sram_lb_n !== ~bmask[bi]) pbad++;
                        if (o_sram_ub_n !== ~bmask[bi+1]) pbad++;
                    end else begin
                        if ({o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n} !== 4'b0100) pbad++;
                    end
                end
            end else begin
                if ({o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n} !== 4'b1111) pbad++;
                if (io_sram_dq !== 16'hFFFF) pbad++;
            end
            if (o_resp_vld) begin
                resp_c = c;
                break;
            end
            if (o_req_rdy !== 1'b0) pbad++;
            tick();
        end
        check_output({tag, " resp cycle"}, 32'(resp_c), 32'(exp_resp));
        check_output({tag, " active cycles"}, 32'(active), 32'(nph * CYC));
        check_output({tag, " pin errors"}, 32'(pbad), 32'd0);
        if (wren) ref_write(w, wdata, bmask);
        else      exp_rdata = ref_read(w);
        check_output({tag, " rdata"}, o_rdata, exp_rdata);
        tick();
        check_output({tag, " resp pulse ends"}, 32'(o_resp_vld), 32'd0);
        check_output({tag, " rdy after resp"}, 32'(o_req_rdy), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [16:0] w;
        logic        wr;
        exp_rdata   = 32'h0;
        hold_addr   = 32'h0;
        i_rstn      = 1'b0;
        i_req_vld   = 1'b0;
        i_req_wren  = 1'b0;
        i_req_addr  = 32'h0;
        i_req_wdata = 32'h0;
        i_req_bmask = 4'h0;

        $display("[TB] reset with random inputs");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            i_req_vld   = 1'($urandom);
            i_req_wren  = 1'($urandom);
            i_req_addr  = $urandom;
            i_req_wdata = $urandom;
            i_req_bmask = 4'($urandom);
            tick();
            if (o_req_rdy !== 1'b1 || o_resp_vld !== 1'b0 || o_sram_ce_n !== 1'b1) bad++;
        end
        check_output("reset hold", 32'(bad), 32'd0);
        check_output("reset rdy", 32'(o_req_rdy), 32'd1);
        check_output("reset strobes", 32'({o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n}), 32'h1F);
        check_output("reset resp", 32'(o_resp_vld), 32'd0);
        check_output("reset rdata", o_rdata, 32'h0);
        check_output("reset addr", 32'(o_sram_addr), 32'h0);
        check_output("reset dq", 32'(io_sram_dq), 32'hFFFF);
        i_req_vld = 1'b0;
        #2 i_rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_req_rdy !== 1'b1 || o_resp_vld !== 1'b0 || io_sram_dq !== 16'hFFFF ||
                {o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n} !== 5'h1F) bad++;
        end
        check_output("idle after release", 32'(bad), 32'd0);

        $display("[TB] directed store/load");
        apply_stimulus("full store", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        apply_stimulus("load back", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);
        check_output("load value", o_rdata, 32'hDEAD_BEEF);
        apply_stimulus("store 104", 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b1111, 1'b0);
        apply_stimulus("partial store", 1'b1, 32'h0000_0104, 32'h00AB_0000, 4'b0100, 1'b0);
        check_output("rdata kept by store", o_rdata, 32'hDEAD_BEEF);
        apply_stimulus("partial reload", 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 1'b0);
        check_output("partial value", o_rdata, 32'h11AB_3344);
        apply_stimulus("mask0 store", 1'b1, 32'h0000_0108, 32'hCAFE_F00D, 4'b0000, 1'b0);

        $display("[TB] request held while busy");
        apply_stimulus("busy store", 1'b1, 32'hF000_0108, 32'h5A5A_1234, 4'b1111, 1'b1);
        apply_stimulus("held load", 1'b0, hold_addr, 32'h0, 4'b0000, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 16; i++) begin
            a       = $urandom;
            w       = 17'h40 + 17'($urandom_range(0, 3));
            a[18:2] = w;
            wr      = 1'($urandom);
            apply_stimulus(wr ? "rand store" : "rand load", wr, a, $urandom, 4'($urandom), 1'b0);
        end

        $display("[TB] reset during HI phase of a load");
        i_req_vld  = 1'b1;
        i_req_wren = 1'b0;
        i_req_addr = 32'h0000_0100;
        tick();
        i_req_vld = 1'b0;
        tick();
        tick();
        check_output("mid HI addr", 32'(o_sram_addr), 32'h081);
        check_output("mid HI oe", 32'(o_sram_oe_n), 32'd0);
        #2 i_rstn = 1'b0;
        #1;
        check_output("abort strobes", 32'({o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n}), 32'h1F);
        check_output("abort dq", 32'(io_sram_dq), 32'hFFFF);
        check_output("abort rdy", 32'(o_req_rdy), 32'd1);
        check_output("abort rdata", o_rdata, 32'h0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_resp_vld !== 1'b0) bad++;
        end
        check_output("abort no resp", 32'(bad), 32'd0);
        #2 i_rstn = 1'b1;
        exp_rdata = 32'h0;
        tick();
        apply_stimulus("load after abort", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Responder on the LSU data-memory request interface. Serves 32-bit load/store requests from the pipeline's MEM stage by driving the board's 256K x 16 asynchronous SRAM.
- Each word access is split into two 16-bit SRAM cycles: low half-word first, then high half-word.
- Sits between the LSU memory-region decode and the top-level SRAM pins.

Parameters:
- WAIT_CYCLES, 1, SRAM access cycles per half-word (>=1). Each half-word phase lasts CYC = WAIT_CYCLES+1 clocks.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_req_vld  input  1  request valid.
- o_req_rdy  output  1  block can accept a request.
- i_req_wren  input  1  1 = store, 0 = load.
- i_req_addr  input  32  byte address; bits [18:2] used, all others ignored.
- i_req_wdata  input  32  store data.
- i_req_bmask  input  4  store byte enables; ignored for loads.
- o_resp_vld  output  1  one-cycle completion pulse (loads and stores).
- o_rdata  output  32  load data.
- o_sram_addr  output  18  half-word address.
- io_sram_dq  inout  16  SRAM data bus.
- o_sram_ce_n  output  1  chip enable, active-low.
- o_sram_we_n  output  1  write enable, active-low.
- o_sram_oe_n  output  1  output enable, active-low.
- o_sram_lb_n  output  1  lower-byte enable, active-low.
- o_sram_ub_n  output  1  upper-byte enable, active-low.

Behaviour:
- Reset: clock and reset are i_clk and i_rstn; reset is asynchronous, active-low.
- Reset values: state=IDLE, o_req_rdy=1, o_resp_vld=0, o_rdata=0, o_sram_addr=0, ce_n/we_n/oe_n/lb_n/ub_n=1, io_sram_dq high-Z.
- FSM states:
  - IDLE -> LO on accept.
  - LO -> HI after CYC cycles, or LO is skipped.
  - HI -> RESP after CYC cycles, or HI is skipped.
  - RESP -> IDLE after one cycle.
- Accept: i_req_vld && o_req_rdy. o_req_rdy is 1 only in IDLE. i_req_vld while busy is ignored and never queued.
- All request fields are latched at accept. Later input changes have no effect on the operation in flight.
- Half-word addressing:
  - LO phase: o_sram_addr = {addr[18:2],1'b0}, data = wdata[15:0], lb/ub from bmask[0]/bmask[1].
  - HI phase: o_sram_addr = {addr[18:2],1'b1}, data = wdata[31:16], lb/ub from bmask[2]/bmask[3].
- Store phase:
  - ce_n=0 and oe_n=1 for all CYC cycles.
  - dq driven for all CYC cycles; address stable throughout.
  - we_n=0 for the first WAIT_CYCLES cycles, 1 on the last cycle (write hold).
- Store skip: a phase whose two mask bits are both 0 is skipped with zero cycles and no SRAM activity.
- Store with mask 0000: IDLE -> RESP directly.
- Load phase:
  - ce_n=0, oe_n=0, lb_n=ub_n=0, we_n=1, dq high-Z.
  - io_sram_dq is sampled at the clock edge ending the phase's last cycle, into o_rdata[15:0] (LO) or o_rdata[31:16] (HI).
  - Both phases always run; byte/half extraction stays in the LSU.
- Outside active phases: pins return to their reset/idle values and dq is high-Z. Address is don't-care while ce_n=1.
- Latency, counting the accept edge as cycle 0:
  - Full access: LO occupies cycles 1..CYC, HI occupies CYC+1..2*CYC, o_resp_vld=1 in cycle 2*CYC+1.
  - Default WAIT_CYCLES=1: response in cycle 5.
  - Store with one phase skipped: response in cycle CYC+1.
  - Store with mask 0000: response in cycle 1.
- Next accept is possible in the cycle after RESP.
- o_rdata holds its value until the next load's samples; stores do not change it.
- Cycle counter: counts 0..WAIT_CYCLES, cleared on every phase entry, no wrap beyond.
- dq direction:
  - dq is driven only in store phases.
  - There is a one-cycle gap (RESP/IDLE) before any later load's oe_n=0, so there is no bus contention.
- Reset mid-operation: all outputs go immediately to their reset values, dq is released, and no o_resp_vld is issued for the aborted request. o_rdata is cleared.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum: IDLE, LO, HI, RESP.
  - SRAM_AW=18, SRAM_DW=16.
  - constants for the address slice bounds (18, 2).
- No sub-module. The tristate driver and FSM are implemented in one module of about 200 lines.

Test Plan:
- Reset: hold i_rstn=0 with random inputs -> o_req_rdy=1, all SRAM strobes 1, dq Z, o_resp_vld=0. Release -> same values until a request arrives.
- Full store: addr=0x100, wdata=0xDEADBEEF, bmask=1111, WAIT_CYCLES=1 -> addr 0x080 with dq 0xBEEF, then addr 0x081 with dq 0xDEAD. we_n low for exactly 1 cycle per phase. o_resp_vld pulse in cycle 5; rdy=0 in cycles 1-5.
- Load back: addr=0x100 with a behavioural SRAM model -> oe_n=0 in cycles 1-4, o_rdata=0xDEADBEEF with o_resp_vld in cycle 5.
- Partial store: addr=0x104, wdata=0x00AB0000, bmask=0100 -> LO skipped; single phase at addr 0x083 with lb_n=0, ub_n=1, dq=0x00AB. Response in cycle 3. Re-load returns the high byte updated and the other bytes unchanged.
- Mask 0000 store -> no ce_n activity, o_resp_vld in cycle 1. A second i_req_vld held through a busy interval is accepted only after return to IDLE.
- Reset asserted during the HI phase of a load -> strobes go to 1 and dq to Z in the same cycle, no o_resp_vld. After release, the next request completes normally.
